// File: rtl/tone_sched_ctrl.sv
// tone_sched_ctrl: two-track piezo tone scheduler.
// Grants the piezo to one of two tracks at a time. Each tone lasts DUR_MS ticks and is
// followed by a GAP_MS-tick silence. When both tracks request at once, round-robin
// arbitration picks the winner.
// Optional feature: define TONE_SCHED_QUEUE_EN to keep one pending request bit per track.
// With the bit, requests that arrive while busy, and tie losers, are served later.
// Without it, such requests are dropped.
module tone_sched_ctrl #(
    parameter int unsigned DUR_MS  = 100,
    parameter int unsigned GAP_MS  = 10,
    parameter int unsigned NOTE_T1 = 95555,
    parameter int unsigned NOTE_T2 = 85131
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic [1:0]  i_req,
    output logic        o_play_en,
    output logic [31:0] o_cnt_limit,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic        o_done
);

    // Terminal counts; GapLast is unused when GAP_MS is 0 because GAP is never entered.
    localparam logic [15:0] DurLast = 16'(DUR_MS - 1);
    localparam logic [15:0] GapLast = (GAP_MS == 0) ? 16'd0 : 16'(GAP_MS - 1);
    localparam bit          GapEn   = (GAP_MS != 0);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_t2_q, last_t2_d;   // 1: Track 2 was granted last
    logic        play_en_q, play_en_d;
    logic [31:0] limit_q, limit_d;
    logic [1:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:0]  req_eff;
    logic [1:0]  win;

`ifdef TONE_SCHED_QUEUE_EN
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  grant_now;

    assign req_eff = i_req | pend_q;

    // Pending bits: merge new requests and clear the one served this cycle.
    always_comb begin
        grant_now = (state_q == StIdle) ? win : 2'b00;
        pend_d    = (pend_q | i_req) & ~grant_now;
    end

    // Pending storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 2'b00;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    assign req_eff = i_req;
`endif

    // Round-robin winner: on a tie, the track not granted last wins.
    always_comb begin
        win = req_eff;
        if (req_eff == 2'b11) begin
            win = last_t2_q ? 2'b01 : 2'b10;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_t2_d = last_t2_q;
        play_en_d = play_en_q;
        limit_d   = limit_q;
        grant_d   = grant_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Counter is held clear so an entry-cycle tick is never counted.
                cnt_d = 16'd0;
                if (win != 2'b00) begin
                    state_d   = StPlay;
                    play_en_d = 1'b1;
                    grant_d   = win;
                    limit_d   = win[0] ? 32'(NOTE_T1) : 32'(NOTE_T2);
                    last_t2_d = win[1];
                end
            end
            StPlay: begin
                if (i_tick) begin
                    if (cnt_q == DurLast) begin
                        cnt_d     = 16'd0;
                        done_d    = 1'b1;
                        play_en_d = 1'b0;
                        limit_d   = 32'd0;
                        grant_d   = 2'b00;
                        state_d   = GapEn ? StGap : StIdle;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StGap: begin
                if (i_tick) begin
                    if (cnt_q == GapLast) begin
                        cnt_d   = 16'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_d     = 16'd0;
                play_en_d = 1'b0;
                limit_d   = 32'd0;
                grant_d   = 2'b00;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset overrides any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            last_t2_q <= 1'b1;
            play_en_q <= 1'b0;
            limit_q   <= 32'd0;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_t2_q <= last_t2_d;
            play_en_q <= play_en_d;
            limit_q   <= limit_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_play_en   = play_en_q;
    assign o_cnt_limit = limit_q;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_tone_sched_ctrl.sv
// Scoreboard bench for tone_sched_ctrl: DUT a (DUR 3, GAP 2) and DUT b (DUR 3, GAP 0).
module tb_tone_sched_ctrl;

    localparam logic [31:0] T1 = 32'd95555;
    localparam logic [31:0] T2 = 32'd85131;

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] limit;
    } tone_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_tick = 1'b0, b_tick = 1'b0;
    logic [1:0]  a_req = 2'b00, b_req = 2'b00;
    logic        a_play_en, b_play_en, a_busy, b_busy, a_done, b_done;
    logic [31:0] a_cnt_limit, b_cnt_limit;
    logic [1:0]  a_grant, b_grant;

    tone_t q_a[$];
    tone_t q_b[$];
    int    n_total = 0;
    int    n_pass  = 0;
    logic  a_prev  = 1'b0;
    logic  b_prev  = 1'b0;

    always #5 clk = ~clk;

    tone_sched_ctrl #(.DUR_MS(3), .GAP_MS(2), .NOTE_T1(95555), .NOTE_T2(85131)) dut_a (
        .clk(clk), .rst(rst), .i_tick(a_tick), .i_req(a_req),
        .o_play_en(a_play_en), .o_cnt_limit(a_cnt_limit), .o_grant(a_grant),
        .o_busy(a_busy), .o_done(a_done)
    );

    tone_sched_ctrl #(.DUR_MS(3), .GAP_MS(0), .NOTE_T1(95555), .NOTE_T2(85131)) dut_b (
        .clk(clk), .rst(rst), .i_tick(b_tick), .i_req(b_req),
        .o_play_en(b_play_en), .o_cnt_limit(b_cnt_limit), .o_grant(b_grant),
        .o_busy(b_busy), .o_done(b_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic tone_t mk(input logic [1:0] g, input logic [31:0] l);
        tone_t t;
        t.grant = g;
        t.limit = l;
        return t;
    endfunction

    // Monitor a: every new tone must match the head of the expected queue.
    always @(negedge clk) begin
        if (a_play_en === 1'b1 && a_prev == 1'b0) begin
            if (q_a.size() == 0) begin
                n_total++;
                $display("FAIL a_unexpected_tone: got grant %b, expected no tone", a_grant);
            end else begin
                tone_t e;
                e = q_a.pop_front();
                check("a_tone_grant", {30'd0, a_grant}, {30'd0, e.grant});
                check("a_tone_limit", a_cnt_limit, e.limit);
            end
        end
        a_prev <= (a_play_en === 1'b1);
    end

    // Monitor b.
    always @(negedge clk) begin
        if (b_play_en === 1'b1 && b_prev == 1'b0) begin
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected_tone: got grant %b, expected no tone", b_grant);
            end else begin
                tone_t e;
                e = q_b.pop_front();
                check("b_tone_grant", {30'd0, b_grant}, {30'd0, e.grant});
                check("b_tone_limit", b_cnt_limit, e.limit);
            end
        end
        b_prev <= (b_play_en === 1'b1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        a_req = 2'b00;
        b_req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic a_pulse(input logic [1:0] v);
        @(negedge clk);
        a_req = v;
        @(negedge clk);
        a_req = 2'b00;
    endtask

    task automatic a_tick_once();
        @(negedge clk);
        a_tick = 1'b1;
        @(negedge clk);
        a_tick = 1'b0;
    endtask

    task automatic b_tick_once();
        @(negedge clk);
        b_tick = 1'b1;
        @(negedge clk);
        b_tick = 1'b0;
    endtask

    // Tick DUT a through every tone it starts until it stays idle.
    task automatic a_drain();
        for (int t = 0; t < 6; t++) begin
            int k;
            repeat (2) @(negedge clk);
            if (!a_busy) break;
            k = 0;
            while (a_busy && k < 40) begin
                a_tick_once();
                k++;
            end
            if (a_busy) begin
                n_total++;
                $display("FAIL a_drain_timeout: got busy 1, expected 0 within 40 ticks");
            end
        end
    endtask

    initial begin
        // Reset with requests asserted: requests are discarded.
        a_req = 2'b11;
        b_req = 2'b11;
        do_reset();
        @(negedge clk);
        check("rst_play_en", a_play_en, 0);
        check("rst_limit", a_cnt_limit, 0);
        check("rst_grant", a_grant, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);

        // Single Track 1 request: timing of play, done and gap.
        q_a.push_back(mk(2'b01, T1));
        a_pulse(2'b01);
        check("t1_play_en", a_play_en, 1);
        check("t1_limit", a_cnt_limit, T1);
        check("t1_grant", a_grant, 2'b01);
        check("t1_busy", a_busy, 1);
        a_tick_once();
        a_tick_once();
        check("t1_done_early", a_done, 0);
        check("t1_still_playing", a_play_en, 1);
        a_tick_once();
        check("t1_done", a_done, 1);
        check("t1_exit_play_en", a_play_en, 0);
        check("t1_exit_limit", a_cnt_limit, 0);
        check("t1_exit_grant", a_grant, 0);
        check("t1_gap_busy", a_busy, 1);
        @(negedge clk);
        check("t1_done_one_clk", a_done, 0);
        a_tick_once();
        check("t1_gap_busy2", a_busy, 1);
        a_tick_once();
        check("t1_idle_busy", a_busy, 0);

        // Tie after reset: Track 1 wins; Track 2 follows only with pending storage.
        do_reset();
        q_a.push_back(mk(2'b01, T1));
`ifdef TONE_SCHED_QUEUE_EN
        q_a.push_back(mk(2'b10, T2));
`endif
        a_pulse(2'b11);
        a_drain();
        check("tie_sb_empty", q_a.size(), 0);

        // Two consecutive ties: round-robin alternation.
        do_reset();
`ifdef TONE_SCHED_QUEUE_EN
        q_a.push_back(mk(2'b01, T1));
        q_a.push_back(mk(2'b10, T2));
        q_a.push_back(mk(2'b01, T1));
        q_a.push_back(mk(2'b10, T2));
`else
        q_a.push_back(mk(2'b01, T1));
        q_a.push_back(mk(2'b10, T2));
`endif
        a_pulse(2'b11);
        a_drain();
        a_pulse(2'b11);
        a_drain();
        check("rr_sb_empty", q_a.size(), 0);

        // Repeated Track 2 requests during a Track 1 tone merge into one.
        do_reset();
        q_a.push_back(mk(2'b01, T1));
`ifdef TONE_SCHED_QUEUE_EN
        q_a.push_back(mk(2'b10, T2));
`endif
        a_pulse(2'b01);
        a_tick_once();
        a_pulse(2'b10);
        a_pulse(2'b10);
        a_tick_once();
        a_pulse(2'b10);
        a_drain();
        check("merge_sb_empty", q_a.size(), 0);

        // Reset mid-tone with both requests asserted.
        do_reset();
        q_a.push_back(mk(2'b01, T1));
        a_pulse(2'b01);
        a_tick_once();
        @(negedge clk);
        rst   = 1'b1;
        a_req = 2'b11;
        @(negedge clk);
        check("midrst_play_en", a_play_en, 0);
        check("midrst_limit", a_cnt_limit, 0);
        check("midrst_grant", a_grant, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_done", a_done, 0);
        rst   = 1'b0;
        a_req = 2'b00;
        repeat (10) @(negedge clk);
        check("midrst_no_tone", a_busy, 0);
        check("midrst_sb_empty", q_a.size(), 0);

        // GAP_MS = 0 on DUT b; a tick on the entry cycle is not counted.
        q_b.push_back(mk(2'b01, T1));
        @(negedge clk);
        b_req  = 2'b01;
        b_tick = 1'b1;
        @(negedge clk);
        b_req  = 2'b00;
        b_tick = 1'b0;
        check("b_play_en", b_play_en, 1);
        b_tick_once();
        b_tick_once();
        check("b_entry_tick_ignored", b_done, 0);
        b_tick_once();
        check("b_done", b_done, 1);
        check("b_busy_low_on_done", b_busy, 0);
        check("b_exit_play_en", b_play_en, 0);
        q_b.push_back(mk(2'b10, T2));
        b_req = 2'b10;
        @(negedge clk);
        b_req = 2'b00;
        check("b_regrant_play_en", b_play_en, 1);
        check("b_regrant_grant", b_grant, 2'b10);
        check("b_regrant_limit", b_cnt_limit, T2);
        b_tick_once();
        b_tick_once();
        b_tick_once();
        check("b_done2", b_done, 1);
        repeat (3) @(negedge clk);
        check("b_sb_empty", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
